// File: rtl/kyber_pkg.sv
// Shared Kyber arithmetic constants for the NTT datapath.
package kyber_pkg;

  localparam int unsigned KYBER_Q    = 3329;
  // floor(2^BARRETT_K / KYBER_Q)
  localparam int unsigned BARRETT_MU = 5039;
  localparam int unsigned BARRETT_K  = 24;
  localparam int unsigned COEFF_W    = 12;
  // Width of a 12x12 product
  localparam int unsigned PROD_W     = 2 * COEFF_W;
  // Partial remainder width: holds values in [0, 2q)
  localparam int unsigned RED_W      = COEFF_W + 1;
  // Width of the Barrett quotient estimate
  localparam int unsigned QH_W       = 13;

endpackage

// File: rtl/cond_sub_q.sv
// Final correction: maps r in [0, 2q) to r mod q with one compare-subtract.
module cond_sub_q
  import kyber_pkg::*;
(
  input  logic [RED_W-1:0]   r_in,
  output logic [COEFF_W-1:0] z_out
);

  logic             borrow;
  logic [RED_W-1:0] diff;

  // Subtract q one bit wider; the borrow selects the unreduced value.
  always_comb begin
    {borrow, diff} = {1'b0, r_in} - (RED_W + 1)'(KYBER_Q);
    z_out          = COEFF_W'(borrow ? r_in : diff);
  end

endmodule

// File: rtl/modular_mul_barrett.sv
// Pipelined z = (a*b) mod 3329 with constant Barrett reduction and valid/ready streaming.
// Optional macro MODMUL_OUT_REG_EN adds a register after the final correction (latency 4).
module modular_mul_barrett
  import kyber_pkg::*;
#(
  parameter int unsigned data_width = 12,
  parameter int unsigned TAG_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [data_width-1:0] a_in,
  input  logic [data_width-1:0] b_in,
  input  logic [TAG_WIDTH-1:0]  tag_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_width-1:0] z_out,
  output logic [TAG_WIDTH-1:0]  tag_out
);

  logic stall;
  logic adv;

  // Stage 1: full product
  logic                 s1_valid_q;
  logic [PROD_W-1:0]    s1_p_q;
  logic [TAG_WIDTH-1:0] s1_tag_q;
  logic [PROD_W-1:0]    s1_p_d;

  // Stage 2: quotient estimate; only the low product bits survive since r < 2^RED_W
  logic                 s2_valid_q;
  logic [RED_W-1:0]     s2_p_q;
  logic [QH_W-1:0]      s2_qh_q;
  logic [TAG_WIDTH-1:0] s2_tag_q;
  logic [QH_W-1:0]      s2_qh_d;

  // Stage 3: partial remainder in [0, 2q)
  logic                 s3_valid_q;
  logic [RED_W-1:0]     s3_r_q;
  logic [TAG_WIDTH-1:0] s3_tag_q;
  logic [RED_W-1:0]     s3_qm_lo;
  logic [RED_W-1:0]     s3_r_d;

  logic [COEFF_W-1:0]   z_red;

  // Global enable: a held output freezes every stage, bubbles included.
  always_comb begin
    adv = ~stall;
  end

  // Datapath arithmetic for each stage input
  always_comb begin
    s1_p_d   = PROD_W'(a_in) * PROD_W'(b_in);
    s2_qh_d  = QH_W'((37'(s1_p_q) * 37'(BARRETT_MU)) >> BARRETT_K);
    // Exact result is below 2^RED_W, so modulo-2^RED_W arithmetic suffices.
    s3_qm_lo = s2_qh_q * RED_W'(KYBER_Q);
    s3_r_d   = s2_p_q - s3_qm_lo;
  end

  // Stage 1 register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_p_q     <= '0;
      s1_tag_q   <= '0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      s1_p_q     <= s1_p_d;
      s1_tag_q   <= tag_in;
    end
  end

  // Stage 2 register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_p_q     <= '0;
      s2_qh_q    <= '0;
      s2_tag_q   <= '0;
    end else if (adv) begin
      s2_valid_q <= s1_valid_q;
      s2_p_q     <= s1_p_q[RED_W-1:0];
      s2_qh_q    <= s2_qh_d;
      s2_tag_q   <= s1_tag_q;
    end
  end

  // Stage 3 register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_valid_q <= 1'b0;
      s3_r_q     <= '0;
      s3_tag_q   <= '0;
    end else if (adv) begin
      s3_valid_q <= s2_valid_q;
      s3_r_q     <= s3_r_d;
      s3_tag_q   <= s2_tag_q;
    end
  end

  cond_sub_q u_cond_sub_q (
    .r_in  (s3_r_q),
    .z_out (z_red)
  );

`ifdef MODMUL_OUT_REG_EN
  logic                 s4_valid_q;
  logic [COEFF_W-1:0]   s4_z_q;
  logic [TAG_WIDTH-1:0] s4_tag_q;

  // Output register after the correction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s4_valid_q <= 1'b0;
      s4_z_q     <= '0;
      s4_tag_q   <= '0;
    end else if (adv) begin
      s4_valid_q <= s3_valid_q;
      s4_z_q     <= z_red;
      s4_tag_q   <= s3_tag_q;
    end
  end

  // Output drive and handshake
  always_comb begin
    out_valid = s4_valid_q;
    z_out     = data_width'(s4_z_q);
    tag_out   = s4_tag_q;
    stall     = out_valid & ~out_ready;
    in_ready  = ~stall;
  end
`else
  // Output drive and handshake
  always_comb begin
    out_valid = s3_valid_q;
    z_out     = data_width'(z_red);
    tag_out   = s3_tag_q;
    stall     = out_valid & ~out_ready;
    in_ready  = ~stall;
  end
`endif

endmodule
